instr_fetch_rom: RTL and testbench

//  Parametrised, clocked successor of the combinational instruction memory.

---
 rtl/instr_fetch_pkg.sv | 30 +++
 rtl/rv32_imm_decode.sv | 33 +++
 rtl/instr_fetch_rom.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_rom.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch ROM.
// Holds the RV32 opcode values, the immediate format and fault encodings,
// the fetch state enum and the packed output-slot payload.
package instr_fetch_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_t;

  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_RANGE = 2'b01;
  localparam logic [1:0] FLT_ALIGN = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAULT} fetch_state_t;

  // Payload of the output slot, registered as one unit.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [1:0]  fault;
  } fetch_slot_t;

endpackage

// File: rtl/rv32_imm_decode.sv
// Combinational RV32 immediate decoder.
// Ports: instr (fetched word) -> fmt_c (instruction format), imm_c (sign-extended immediate).
module rv32_imm_decode
  import instr_fetch_pkg::*;
(
  input  logic [31:0] instr,
  output imm_fmt_t    fmt_c,
  output logic [31:0] imm_c
);

  // Format from opcode, then immediate assembled per format.
  always_comb begin
    fmt_c = FMT_R;
    imm_c = 32'h0;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt_c = FMT_I;
      OPC_STORE:                      fmt_c = FMT_S;
      OPC_BRANCH:                     fmt_c = FMT_B;
      OPC_LUI, OPC_AUIPC:             fmt_c = FMT_U;
      OPC_JAL:                        fmt_c = FMT_J;
      default:                        fmt_c = FMT_R;
    endcase
    case (fmt_c)
      FMT_I:   imm_c = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm_c = {instr[31:12], 12'h000};
      FMT_J:   imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_c = 32'h0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_rom.sv
// Clocked instruction fetch from a byte-addressed program ROM.
// Fetches one big-endian 32-bit word per cycle into a registered output slot,
// decodes RV32 fields and the immediate, and hands the slot over valid/ready.
// A redirect reloads the PC and flushes the slot; out-of-range fetches fault.
// Ports: clk, rst (async, active-high), redirect_valid/redirect_pc (branch unit),
//   out_ready (consumer), out_valid/out_pc/out_instr/out_rd/out_rs1/out_rs2/
//   out_opcode/out_funct3/out_imm/out_fault (decode stage).
// Build option: MISALIGN_CHECK_EN enables the misaligned-fetch fault; without it
//   PC bits [1:0] are forced to zero whenever the PC is loaded.
// The ROM image is supplied as INIT_IMAGE (byte a at bits [8a+7:8a]); INIT_FILE
//   names the hex source that image is generated from.
module instr_fetch_rom
  import instr_fetch_pkg::*;
#(
  parameter int unsigned                 ADDR_W      = 7,
  parameter int unsigned                 DEPTH_WORDS = 32,
  parameter int unsigned                 RESET_PC    = 0,
  parameter string                       INIT_FILE   = "prog.hex",
  parameter logic [DEPTH_WORDS*32-1:0]   INIT_IMAGE  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_instr,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [6:0]        out_opcode,
  output logic [2:0]        out_funct3,
  output logic [31:0]       out_imm,
  output logic [1:0]        out_fault
);

  localparam int unsigned ROM_BYTES = DEPTH_WORDS * 4;
  localparam int unsigned PCX_W     = ADDR_W + 1;
  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
`ifdef MISALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] PC_MASK = '1;
`else
  localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(3);
`endif
  localparam logic [ADDR_W-1:0] RESET_PC_L = ADDR_W'(RESET_PC) & PC_MASK;

  // ROM words assembled big-endian from the byte image.
  logic [31:0] rom [DEPTH_WORDS];
  for (genvar w = 0; w < DEPTH_WORDS; w++) begin : g_rom
    assign rom[w] = {INIT_IMAGE[32*w +: 8], INIT_IMAGE[32*w+8 +: 8],
                     INIT_IMAGE[32*w+16 +: 8], INIT_IMAGE[32*w+24 +: 8]};
  end

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, out_pc_n;
  logic              out_valid_n;
  fetch_slot_t       slot, slot_n;

  logic              range_flt_c, align_flt_c;
  logic [31:0]       word_c, imm_c;
  imm_fmt_t          fmt_c;
  logic              unused_sink;

  // Fault detection on the current PC; the read is gated so it never indexes past the ROM.
  assign range_flt_c = ({1'b0, pc} >= PCX_W'(ROM_BYTES));
`ifdef MISALIGN_CHECK_EN
  assign align_flt_c = (pc[1:0] != 2'b00);
`else
  assign align_flt_c = 1'b0;
`endif
  assign word_c = range_flt_c ? 32'h0 : rom[IDX_W'(pc[ADDR_W-1:2])];

  rv32_imm_decode u_imm_decode (
    .instr (word_c),
    .fmt_c (fmt_c),
    .imm_c (imm_c)
  );

  assign unused_sink = (fmt_c == FMT_R) ^ (INIT_FILE == "");

  // State, PC and slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC_L;
      out_valid <= 1'b0;
      out_pc    <= '0;
      slot      <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      out_valid <= out_valid_n;
      out_pc    <= out_pc_n;
      slot      <= slot_n;
    end
  end

  // Next-state: slot load in RUN when the slot is free or being taken; redirect overrides all.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    out_valid_n = out_valid;
    out_pc_n    = out_pc;
    slot_n      = slot;
    case (state)
      ST_IDLE: state_n = ST_RUN;
      ST_RUN: begin
        if (!out_valid || out_ready) begin
          out_valid_n = 1'b1;
          out_pc_n    = pc;
          if (align_flt_c) begin
            slot_n  = '{instr: 32'h0, imm: 32'h0, fault: FLT_ALIGN};
            state_n = ST_FAULT;
          end else if (range_flt_c) begin
            slot_n  = '{instr: 32'h0, imm: 32'h0, fault: FLT_RANGE};
            state_n = ST_FAULT;
          end else begin
            slot_n = '{instr: word_c, imm: imm_c, fault: FLT_NONE};
            pc_n   = pc + ADDR_W'(4);
          end
        end
      end
      ST_FAULT: begin
        if (out_valid && out_ready) out_valid_n = 1'b0;
      end
      default: state_n = ST_IDLE;
    endcase
    if (redirect_valid) begin
      out_valid_n = 1'b0;
      pc_n        = redirect_pc & PC_MASK;
      state_n     = ST_RUN;
    end
  end

  assign out_instr  = slot.instr;
  assign out_imm    = slot.imm;
  assign out_fault  = slot.fault;
  assign out_rd     = slot.instr[11:7];
  assign out_rs1    = slot.instr[19:15];
  assign out_rs2    = slot.instr[24:20];
  assign out_opcode = slot.instr[6:0];
  assign out_funct3 = slot.instr[14:12];

endmodule

// File: tb/tb_instr_fetch_rom.sv
// Self-checking bench for instr_fetch_rom: a transaction scoreboard predicts
// every presented slot from the program table, plus directed literal checks.
module tb_instr_fetch_rom;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned BYTES  = DEPTH * 4;
  localparam int unsigned PC_MOD = 1 << ADDR_W;

  function automatic logic [31:0] prog_word(input int unsigned i);
    case (i)
      0:       return 32'h00450693;  // addi x13,x10,4
      1:       return 32'h00c58733;  // add (R)
      2:       return 32'hfe0796e3;  // bne, imm -20
      3:       return 32'hfc1ff06f;  // jal, imm -64
      4:       return 32'h01162023;  // sw, imm 0
      5:       return 32'h123452b7;  // lui
      6:       return 32'hfff00513;  // addi -1
      7:       return 32'hfe112e23;  // sw -4
      8:       return 32'h00a00093;  // addi x1,x0,10
      9:       return 32'h00001097;  // auipc
      default: return 32'h00100013 | (32'(i) << 7);
    endcase
  endfunction

  function automatic logic [DEPTH*32-1:0] build_image();
    logic [DEPTH*32-1:0] img;
    logic [31:0] w;
    img = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w = prog_word(i);
      img[32*i +: 8]    = w[31:24];
      img[32*i+8 +: 8]  = w[23:16];
      img[32*i+16 +: 8] = w[15:8];
      img[32*i+24 +: 8] = w[7:0];
    end
    return img;
  endfunction

  localparam logic [DEPTH*32-1:0] IMG = build_image();

  logic              clk, rst, redirect_valid, out_ready;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [31:0]       out_instr, out_imm;
  logic [4:0]        out_rd, out_rs1, out_rs2;
  logic [6:0]        out_opcode;
  logic [2:0]        out_funct3;
  logic [1:0]        out_fault;

  instr_fetch_rom #(
    .ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .RESET_PC(0), .INIT_FILE(""), .INIT_IMAGE(IMG)
  ) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_imm(out_imm), .out_fault(out_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  // Immediate from the ISA definition, using arithmetic rather than bit concatenation.
  function automatic logic [31:0] model_imm(input logic [31:0] w);
    case (w[6:0])
      7'h03, 7'h13, 7'h67: return $unsigned($signed(w) >>> 20);
      7'h23: return ($unsigned($signed(w) >>> 20) & ~32'h1f) | ((w >> 7) & 32'h1f);
      7'h63: return (w[31] ? 32'hfffff000 : 32'h0) | (w[7] ? 32'h800 : 32'h0)
                    | ((w >> 20) & 32'h7e0) | ((w >> 7) & 32'h1e);
      7'h37, 7'h17: return w & 32'hfffff000;
      7'h6f: return (w[31] ? 32'hfff00000 : 32'h0) | (w & 32'h000ff000)
                    | ((w >> 9) & 32'h800) | ((w >> 20) & 32'h7fe);
      default: return 32'h0;
    endcase
  endfunction

  typedef struct packed {
    logic [1:0]  fault;
    logic [31:0] instr;
    logic [31:0] imm;
  } exp_t;

  function automatic int unsigned tgt(input int unsigned a);
`ifdef MISALIGN_CHECK_EN
    return a;
`else
    return a & ~32'd3;
`endif
  endfunction

  function automatic exp_t expect_at(input int unsigned a);
    exp_t e;
    e = '0;
`ifdef MISALIGN_CHECK_EN
    if (a % 4 != 0) begin
      e.fault = 2'b10;
      return e;
    end
`endif
    if (a >= BYTES) e.fault = 2'b01;
    else begin
      e.instr = prog_word(a / 4);
      e.imm   = model_imm(e.instr);
    end
    return e;
  endfunction

  // Scoreboard: address of the next slot to be presented, halt after an accepted fault.
  int unsigned exp_addr;
  bit          halted;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_addr = tgt(0);
      halted   = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (expect_at(exp_addr).fault != 2'b00) halted = 1'b1;
        exp_addr = (exp_addr + 4) % PC_MOD;
      end
      if (redirect_valid) begin
        exp_addr = tgt(32'(redirect_pc));
        halted   = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (halted) chk("sb_no_valid_after_fault", 32'(out_valid), 32'd0);
      else if (out_valid) begin
        e = expect_at(exp_addr);
        chk("sb_pc",     32'(out_pc),     32'(exp_addr));
        chk("sb_instr",  out_instr,       e.instr);
        chk("sb_imm",    out_imm,         e.imm);
        chk("sb_fault",  32'(out_fault),  32'(e.fault));
        chk("sb_fields", {5'(out_rd), 5'(out_rs1), 5'(out_rs2), 7'(out_opcode), 3'(out_funct3), 7'd0},
                         {e.instr[11:7], e.instr[19:15], e.instr[24:20], e.instr[6:0], e.instr[14:12], 7'd0});
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic redirect(input logic [ADDR_W-1:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc",    32'(out_pc),    32'd0);
    chk("rst_instr", out_instr,      32'd0);
    chk("rst_imm",   out_imm,        32'd0);
    chk("rst_fault", 32'(out_fault), 32'd0);

    // Reset release: one idle cycle, then word 0, then back-to-back.
    rst = 1'b0; out_ready = 1'b1;
    step(); chk("idle_cycle_valid", 32'(out_valid), 32'd0);
    step();
    chk("w0_valid", 32'(out_valid), 32'd1);
    chk("w0_instr", out_instr, 32'h00450693);
    chk("w0_pc",    32'(out_pc), 32'h00);
    chk("w0_rd",    32'(out_rd), 32'd13);
    chk("w0_rs1",   32'(out_rs1), 32'd10);
    chk("w0_imm",   out_imm, 32'd4);
    step(); chk("w1_pc", 32'(out_pc), 32'h04);
    step(); chk("bne_imm", out_imm, 32'hffffffec);
    step(); chk("jal_imm", out_imm, 32'hffffffc0);
    step(); chk("sw_instr", out_instr, 32'h01162023); chk("sw_imm", out_imm, 32'h0);

    // Stall three cycles on the sw slot.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_pc",    32'(out_pc), 32'h10);
      chk("stall_instr", out_instr, 32'h01162023);
    end
    out_ready = 1'b1;
    step(); chk("after_stall_pc", 32'(out_pc), 32'h14); chk("lui_imm", out_imm, 32'h12345000);

    // Redirect during stall.
    out_ready = 1'b0;
    step(); chk("stall2_pc", 32'(out_pc), 32'h14);
    redirect(7'h20); out_ready = 1'b1;
    chk("redir_flush", 32'(out_valid), 32'd0);
    step();
    chk("redir_valid", 32'(out_valid), 32'd1);
    chk("redir_pc",    32'(out_pc), 32'h20);
    chk("redir_instr", out_instr, 32'h00a00093);

    // Redirect while the slot is being accepted.
    redirect(7'h08);
    chk("redir_acc_flush", 32'(out_valid), 32'd0);
    step(); chk("redir_acc_pc", 32'(out_pc), 32'h08);

    // Run off the end of the ROM.
    redirect(7'h38);
    step(); chk("tail_pc", 32'(out_pc), 32'h38);
    step(); chk("tail_pc2", 32'(out_pc), 32'h3c);
    step();
    chk("range_valid", 32'(out_valid), 32'd1);
    chk("range_fault", 32'(out_fault), 32'd1);
    chk("range_instr", out_instr, 32'd0);
    chk("range_imm",   out_imm, 32'd0);
    chk("range_pc",    32'(out_pc), 32'h40);
    for (int i = 0; i < 5; i++) begin
      step(); chk("fault_idle", 32'(out_valid), 32'd0);
    end
    redirect(7'h00);
    step(); chk("resume_pc", 32'(out_pc), 32'h00); chk("resume_instr", out_instr, 32'h00450693);

    // Misaligned redirect.
    redirect(7'h06);
    step();
`ifdef MISALIGN_CHECK_EN
    chk("misalign_fault", 32'(out_fault), 32'd2);
    chk("misalign_pc",    32'(out_pc), 32'h06);
`else
    chk("misalign_fault", 32'(out_fault), 32'd0);
    chk("misalign_pc",    32'(out_pc), 32'h04);
    chk("misalign_instr", out_instr, 32'h00c58733);
`endif
    redirect(7'h00);
    step(); chk("recover_pc", 32'(out_pc), 32'h00);

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    step(); chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1 chk("async_rst_valid", 32'(out_valid), 32'd0);
    step();
    rst = 1'b0; out_ready = 1'b1;
    step(); chk("rst2_idle", 32'(out_valid), 32'd0);
    step(); chk("rst2_pc", 32'(out_pc), 32'h00); chk("rst2_instr", out_instr, 32'h00450693);

    // Irregular ready pattern through to the range fault.
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 3 != 0);
      step();
    end
    out_ready = 1'b1;
    step(); step();
    chk("end_halted", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
